// File: rtl/frc_intr_gen.sv
`default_nettype none
// ============================================================================
// Module     : frc_intr_gen
// Description: Free-running 64-bit timer (mtime) with compare register
//              (mtimecmp) and synchronised external interrupt source.
//              It drives the interrupt level, a rising-edge pulse and the
//              registered compare flag that the PC stage consumes.
//              Registers are accessed over a single-cycle 32-bit word bus.
// Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: FRC_PRESCALE_EN
//   Defined   - adr 6 holds a PRESC_W-bit prescaler. mtime ticks every
//               presc+1 clocks.
//   Undefined - mtime ticks every clock. adr 6 reads 0 and ignores writes.
// ----------------------------------------------------------------------------
// Ports:
//   clk               in   system clock, posedge
//   rst               in   synchronous active-high reset
//   ext_intr_in       in   asynchronous level external interrupt request
//   bus_adr[2:0]      in   0 mtime_lo, 1 mtime_hi, 2 cmp_lo, 3 cmp_hi,
//                          4 status, 5 enable, 6 presc, 7 reserved
//   bus_we            in   write strobe
//   bus_re            in   read strobe
//   bus_wdata[31:0]   in   write data
//   bus_rdata[31:0]   out  read data, registered, held until next bus_re
//   g_interrupt       out  pending & enable (registered)
//   g_interrupt_1shot out  1-cycle pulse on the rise of g_interrupt
//   frc_cntr_val_leq  out  registered (mtimecmp <= mtime), unsigned
// ============================================================================
module frc_intr_gen #(
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_intr_in,
  input  logic [2:0]  bus_adr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        g_interrupt,
  output logic        g_interrupt_1shot,
  output logic        frc_cntr_val_leq
);

  localparam logic [2:0] ADR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADR_STATUS   = 3'd4;
  localparam logic [2:0] ADR_ENABLE   = 3'd5;
  localparam logic [2:0] ADR_PRESC    = 3'd6;

  logic [CNT_W-1:0]   mtime;
  logic [CNT_W-1:0]   mtimecmp;
  logic [31:0]        hi_snap;
  logic               pending;
  logic               enable;
  logic               sync1;
  logic               sync2;
  logic               sync2_d;
  logic               tick;
  logic [PRESC_W-1:0] presc_val;
  logic [31:0]        rd_mux;
  logic               set_edge;
  logic               w1c;

  assign set_edge = sync2 & ~sync2_d;
  assign w1c      = bus_we && (bus_adr == ADR_STATUS) && bus_wdata[0];

`ifdef FRC_PRESCALE_EN
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;

  // Down-counter ticks on 0 and reloads, giving one tick every presc+1 clocks.
  // A presc write reloads it so the new rate starts immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else if (bus_we && (bus_adr == ADR_PRESC)) begin
      presc     <= bus_wdata[PRESC_W-1:0];
      presc_cnt <= bus_wdata[PRESC_W-1:0];
    end else if (presc_cnt == '0) begin
      presc_cnt <= presc;
    end else begin
      presc_cnt <= presc_cnt - PRESC_W'(1);
    end
  end

  assign tick      = (presc_cnt == '0);
  assign presc_val = presc;
`else
  assign tick      = 1'b1;
  assign presc_val = '0;
`endif

  // Read mux samples pre-write state, so a same-cycle read+write returns old data.
  always_comb begin
    rd_mux = '0;
    case (bus_adr)
      ADR_MTIME_LO: rd_mux = mtime[31:0];
      ADR_MTIME_HI: rd_mux = hi_snap;
      ADR_CMP_LO:   rd_mux = mtimecmp[31:0];
      ADR_CMP_HI:   rd_mux = mtimecmp[CNT_W-1:32];
      ADR_STATUS:   rd_mux = {30'd0, frc_cntr_val_leq, pending};
      ADR_ENABLE:   rd_mux = {31'd0, enable};
      ADR_PRESC:    rd_mux = {{(32-PRESC_W){1'b0}}, presc_val};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime             <= '0;
      mtimecmp          <= '1;
      hi_snap           <= '0;
      pending           <= 1'b0;
      enable            <= 1'b0;
      sync1             <= 1'b0;
      sync2             <= 1'b0;
      sync2_d           <= 1'b0;
      bus_rdata         <= '0;
      g_interrupt       <= 1'b0;
      g_interrupt_1shot <= 1'b0;
      frc_cntr_val_leq  <= 1'b0;
    end else begin
      // Half-word writes replace only their half and suppress the tick,
      // so no carry crosses halves during a write cycle.
      if (bus_we && (bus_adr == ADR_MTIME_LO)) begin
        mtime[31:0] <= bus_wdata;
      end else if (bus_we && (bus_adr == ADR_MTIME_HI)) begin
        mtime[CNT_W-1:32] <= bus_wdata;
      end else if (tick) begin
        mtime <= mtime + CNT_W'(1);
      end

      if (bus_we && (bus_adr == ADR_CMP_LO)) mtimecmp[31:0]      <= bus_wdata;
      if (bus_we && (bus_adr == ADR_CMP_HI)) mtimecmp[CNT_W-1:32] <= bus_wdata;
      if (bus_we && (bus_adr == ADR_ENABLE)) enable               <= bus_wdata[0];

      // A lo read freezes the high half so the following hi read is coherent.
      if (bus_re && (bus_adr == ADR_MTIME_LO)) hi_snap <= mtime[CNT_W-1:32];
      if (bus_re) bus_rdata <= rd_mux;

      sync1   <= ext_intr_in;
      sync2   <= sync1;
      sync2_d <= sync2;

      // Set has priority over the W1C clear.
      if (set_edge) begin
        pending <= 1'b1;
      end else if (w1c) begin
        pending <= 1'b0;
      end

      g_interrupt       <= pending & enable;
      g_interrupt_1shot <= pending & enable & ~g_interrupt;
      frc_cntr_val_leq  <= (mtimecmp <= mtime);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frc_intr_gen.sv
`default_nettype none
// ============================================================================
// Module     : tb_frc_intr_gen
// Description: Directed self-checking bench for frc_intr_gen (default build,
//              prescaler disabled). Inputs change 1 ns after each rising
//              edge. Outputs are sampled at the same point.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_frc_intr_gen;

  logic        clk;
  logic        rst;
  logic        ext_intr_in;
  logic [2:0]  bus_adr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        g_interrupt;
  logic        g_interrupt_1shot;
  logic        frc_cntr_val_leq;

  int vectors     = 0;
  int miscompares = 0;

  frc_intr_gen dut (
    .clk               (clk),
    .rst               (rst),
    .ext_intr_in       (ext_intr_in),
    .bus_adr           (bus_adr),
    .bus_we            (bus_we),
    .bus_re            (bus_re),
    .bus_wdata         (bus_wdata),
    .bus_rdata         (bus_rdata),
    .g_interrupt       (g_interrupt),
    .g_interrupt_1shot (g_interrupt_1shot),
    .frc_cntr_val_leq  (frc_cntr_val_leq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_adr   = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    step();
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_adr = a;
    bus_re  = 1'b1;
    step();
    bus_re  = 1'b0;
    d       = bus_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    rst         = 1'b1;
    ext_intr_in = 1'b0;
    bus_adr     = 3'd0;
    bus_we      = 1'b0;
    bus_re      = 1'b0;
    bus_wdata   = '0;

    // Reset state
    repeat (3) step();
    chk("rst_gint",  {31'd0, g_interrupt}, 32'd0);
    chk("rst_1shot", {31'd0, g_interrupt_1shot}, 32'd0);
    chk("rst_leq",   {31'd0, frc_cntr_val_leq}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    rst = 1'b0;
    bus_read(3'd0, rd);
    chk("rst_mtime_lo", rd, 32'd0);

    // Idle count: mtime is 1 after that read, 11 after 10 more clocks
    repeat (10) step();
    bus_read(3'd0, rd);
    chk("idle_lo", rd, 32'd11);
    bus_read(3'd1, rd);
    chk("idle_hi", rd, 32'd0);
    chk("idle_gint", {31'd0, g_interrupt}, 32'd0);
    chk("idle_leq",  {31'd0, frc_cntr_val_leq}, 32'd0);

    // Compare: cmp=20, mtime restarted at 0 then 1 after the cmp_lo write
    bus_write(3'd3, 32'd0);
    bus_write(3'd0, 32'd0);
    bus_write(3'd2, 32'd20);
    repeat (19) step();               // mtime reaches 20 here
    chk("leq_before", {31'd0, frc_cntr_val_leq}, 32'd0);
    step();
    chk("leq_after",  {31'd0, frc_cntr_val_leq}, 32'd1);
    bus_read(3'd4, rd);
    chk("status_leq", rd, 32'd2);
    bus_write(3'd3, 32'hFFFF_FFFF);   // park compare far away

    // Carry across halves
    bus_write(3'd0, 32'hFFFF_FFFE);
    bus_write(3'd1, 32'd0);
    repeat (2) step();
    bus_read(3'd0, rd);
    chk("carry_lo", rd, 32'd0);
    bus_read(3'd1, rd);
    chk("carry_hi", rd, 32'd1);
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read(3'd0, rd);               // mtime rolls to 1_0000_0000 at this edge
    chk("coh_lo", rd, 32'hFFFF_FFFF);
    bus_read(3'd1, rd);
    chk("coh_hi", rd, 32'd0);
    chk("carry_leq", {31'd0, frc_cntr_val_leq}, 32'd0);

    // External interrupt: ext edge -> pending 3 clk -> g_interrupt 1 clk
    bus_write(3'd5, 32'd1);
    ext_intr_in = 1'b1;
    repeat (3) step();
    chk("ext_gint_early", {31'd0, g_interrupt}, 32'd0);
    step();
    chk("ext_gint_rise",  {31'd0, g_interrupt}, 32'd1);
    chk("ext_1shot_rise", {31'd0, g_interrupt_1shot}, 32'd1);
    step();
    chk("ext_1shot_drop", {31'd0, g_interrupt_1shot}, 32'd0);
    chk("ext_gint_hold",  {31'd0, g_interrupt}, 32'd1);
    bus_read(3'd4, rd);
    chk("ext_status", rd, 32'd1);
    bus_write(3'd4, 32'd1);
    chk("w1c_gint_same", {31'd0, g_interrupt}, 32'd1);
    step();
    chk("w1c_gint_low",  {31'd0, g_interrupt}, 32'd0);
    repeat (5) step();
    bus_read(3'd4, rd);
    chk("level_no_reset", rd, 32'd0);

    // W1C in the same cycle as a new sync edge: set wins
    ext_intr_in = 1'b0;
    repeat (4) step();
    bus_write(3'd5, 32'd0);
    ext_intr_in = 1'b1;
    repeat (2) step();
    bus_write(3'd4, 32'd1);           // lands on the edge that sets pending
    bus_read(3'd4, rd);
    chk("setwins_status", rd, 32'd1);
    chk("setwins_gint",   {31'd0, g_interrupt}, 32'd0);
    bus_write(3'd5, 32'd1);
    chk("en_gint_same", {31'd0, g_interrupt}, 32'd0);
    step();
    chk("en_gint_rise",  {31'd0, g_interrupt}, 32'd1);
    chk("en_1shot_rise", {31'd0, g_interrupt_1shot}, 32'd1);
    step();
    chk("en_1shot_drop", {31'd0, g_interrupt_1shot}, 32'd0);

    // Gating keeps pending; re-enable fires 1shot again
    bus_write(3'd5, 32'd0);
    step();
    chk("gate_gint_low", {31'd0, g_interrupt}, 32'd0);
    bus_read(3'd4, rd);
    chk("gate_pending", rd, 32'd1);
    bus_write(3'd5, 32'd1);
    step();
    chk("reen_1shot", {31'd0, g_interrupt_1shot}, 32'd1);

    // Bus conflicts and unused addresses
    bus_adr   = 3'd5;
    bus_wdata = 32'd0;
    bus_re    = 1'b1;
    bus_we    = 1'b1;
    step();
    bus_re    = 1'b0;
    bus_we    = 1'b0;
    chk("rw_prewrite", bus_rdata, 32'd1);
    bus_read(3'd5, rd);
    chk("rw_postwrite", rd, 32'd0);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, rd);
    chk("enable_bit0", rd, 32'd1);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, rd);
    chk("adr7_zero", rd, 32'd0);
    bus_read(3'd6, rd);
    chk("presc_off_zero", rd, 32'd0);
    bus_read(3'd2, rd);
    chk("cmp_lo_rb", rd, 32'd20);
    bus_read(3'd3, rd);
    chk("cmp_hi_rb", rd, 32'hFFFF_FFFF);
    chk("pre_rst_gint", {31'd0, g_interrupt}, 32'd1);

    // Reset mid-operation with a concurrent mtime write that must be dropped
    ext_intr_in = 1'b0;
    bus_adr     = 3'd0;
    bus_wdata   = 32'h0000_1234;
    bus_we      = 1'b1;
    rst         = 1'b1;
    step();
    bus_we      = 1'b0;
    chk("mid_rst_gint",  {31'd0, g_interrupt}, 32'd0);
    chk("mid_rst_1shot", {31'd0, g_interrupt_1shot}, 32'd0);
    chk("mid_rst_leq",   {31'd0, frc_cntr_val_leq}, 32'd0);
    chk("mid_rst_rdata", bus_rdata, 32'd0);
    rst = 1'b0;
    bus_read(3'd0, rd);
    chk("mid_rst_mtime", rd, 32'd0);
    bus_read(3'd3, rd);
    chk("mid_rst_cmp_hi", rd, 32'hFFFF_FFFF);
    bus_read(3'd4, rd);
    chk("mid_rst_status", rd, 32'd0);
    bus_read(3'd5, rd);
    chk("mid_rst_enable", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
